// File: rtl/spi_txn_arb.sv
// spi_txn_arb: round-robin arbiter feeding one SPI engine from two requesters (optional watchdog: SPI_ARB_TIMEOUT_EN).
// Grant is combinational in IDLE; the word is streamed from the next cycle and the response strobes one cycle after eot_i.
module spi_txn_arb #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic        pclk_i,
  input  logic        prst_i,
  input  logic        req0_vld_i,
  input  logic [31:0] req0_data_i,
  output logic        req0_rdy_o,
  input  logic        req1_vld_i,
  input  logic [31:0] req1_data_i,
  output logic        req1_rdy_o,
  output logic        resp0_vld_o,
  output logic        resp1_vld_o,
  output logic [31:0] resp_data_o,
  output logic [31:0] stream_data_o,
  output logic        stream_data_vld_o,
  input  logic        eot_i,
  input  logic [31:0] spi_data_rx_i,
  input  logic        spi_data_rx_vld_i,
  output logic        busy_o,
  output logic        owner_o,
  output logic        timeout_o
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_EOT = 2'd1;
  localparam logic [1:0] ST_RESP     = 2'd2;

  localparam logic [31:0] TIMEOUT_WORD = 32'h0bad_da7a;

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic [31:0] word_q, word_d;
  logic [31:0] cap_q, cap_d;
  logic        gnt_any;
  logic        gnt1;
  logic        expired;

  // Requester 1 wins only when it is alone or requester 0 held the last grant.
  assign gnt_any = (state_q == ST_IDLE) && !prst_i && (req0_vld_i || req1_vld_i);
  assign gnt1    = req1_vld_i && (!req0_vld_i || !owner_q);

  assign req0_rdy_o = gnt_any && !gnt1;
  assign req1_rdy_o = gnt_any && gnt1;

`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;

  // Expiry fires on the cycle the count steps onto TIMEOUT_CYCLES-1, so RESP lands TIMEOUT_CYCLES after issue.
  assign expired = (state_q == ST_WAIT_EOT) && ((cnt_q + 16'd1) == (TIMEOUT_CYCLES - 16'd1));

  always_comb begin
    cnt_d = cnt_q;
    if (gnt_any) begin
      cnt_d = 16'd0;
    end else if (state_q == ST_WAIT_EOT) begin
      cnt_d = cnt_q + 16'd1;
    end
    timeout_d = (state_q == ST_WAIT_EOT) && !eot_i && expired;
  end

  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      cnt_q     <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic to_param_unused;
  assign to_param_unused = ^TIMEOUT_CYCLES;
  assign expired   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    word_d  = word_q;
    cap_d   = cap_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          state_d = ST_WAIT_EOT;
          owner_d = gnt1;
          word_d  = gnt1 ? req1_data_i : req0_data_i;
          cap_d   = 32'd0;
        end
      end
      ST_WAIT_EOT: begin
        if (spi_data_rx_vld_i) begin
          cap_d = spi_data_rx_i;
        end
        if (eot_i) begin
          state_d = ST_RESP;
        end else if (expired) begin
          state_d = ST_RESP;
          cap_d   = TIMEOUT_WORD;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b1;
      word_q  <= 32'd0;
      cap_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      word_q  <= word_d;
      cap_q   <= cap_d;
    end
  end

  assign resp0_vld_o       = (state_q == ST_RESP) && !owner_q;
  assign resp1_vld_o       = (state_q == ST_RESP) && owner_q;
  assign resp_data_o       = cap_q;
  assign stream_data_o     = word_q;
  assign stream_data_vld_o = (state_q == ST_WAIT_EOT);
  assign busy_o            = (state_q != ST_IDLE);
  assign owner_o           = owner_q;

endmodule

// File: tb/tb_spi_txn_arb.sv
// Bench for spi_txn_arb: directed vector table, hand-written corner sequences and a randomized run against a model.
module tb_spi_txn_arb;

  localparam logic [15:0] TO = 16'd8;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        pclk_i = 1'b0;
  logic        prst_i = 1'b1;
  logic        req0_vld_i = 1'b0, req1_vld_i = 1'b0;
  logic [31:0] req0_data_i = 32'd0, req1_data_i = 32'd0;
  logic        req0_rdy_o, req1_rdy_o, resp0_vld_o, resp1_vld_o;
  logic [31:0] resp_data_o, stream_data_o;
  logic        stream_data_vld_o;
  logic        eot_i = 1'b0;
  logic [31:0] spi_data_rx_i = 32'd0;
  logic        spi_data_rx_vld_i = 1'b0;
  logic        busy_o, owner_o, timeout_o;

  spi_txn_arb #(.TIMEOUT_CYCLES(TO)) dut (
    .pclk_i(pclk_i), .prst_i(prst_i),
    .req0_vld_i(req0_vld_i), .req0_data_i(req0_data_i), .req0_rdy_o(req0_rdy_o),
    .req1_vld_i(req1_vld_i), .req1_data_i(req1_data_i), .req1_rdy_o(req1_rdy_o),
    .resp0_vld_o(resp0_vld_o), .resp1_vld_o(resp1_vld_o), .resp_data_o(resp_data_o),
    .stream_data_o(stream_data_o), .stream_data_vld_o(stream_data_vld_o),
    .eot_i(eot_i), .spi_data_rx_i(spi_data_rx_i), .spi_data_rx_vld_i(spi_data_rx_vld_i),
    .busy_o(busy_o), .owner_o(owner_o), .timeout_o(timeout_o)
  );

  always #5 pclk_i = ~pclk_i;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge pclk_i);
    #1;
  endtask

  task automatic clear_inputs();
    req0_vld_i = 1'b0; req1_vld_i = 1'b0;
    req0_data_i = 32'd0; req1_data_i = 32'd0;
    eot_i = 1'b0; spi_data_rx_vld_i = 1'b0; spi_data_rx_i = 32'd0;
  endtask

  task automatic do_reset(input bit check);
    clear_inputs();
    prst_i = 1'b1;
    tick();
    if (check) begin
      @(negedge pclk_i);
      chk("rst_rdy0", req0_rdy_o, 1'b0);
      chk("rst_rdy1", req1_rdy_o, 1'b0);
      chk("rst_resp0", resp0_vld_o, 1'b0);
      chk("rst_resp1", resp1_vld_o, 1'b0);
      chk("rst_svld", stream_data_vld_o, 1'b0);
      chk("rst_sdata", stream_data_o, 32'd0);
      chk("rst_rdata", resp_data_o, 32'd0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_owner", owner_o, 1'b1);
      chk("rst_timeout", timeout_o, 1'b0);
    end
    tick();
    prst_i = 1'b0;
  endtask

  typedef struct {
    logic r0, r1;
    logic [31:0] d0, d1;
    logic eot, rxv;
    logic [31:0] rx;
    logic e_rdy0, e_rdy1, e_svld, e_resp0, e_resp1, e_busy, e_owner;
    logic [31:0] e_sdata, e_rdata;
  } vec_t;

  vec_t vt [13];

  // Reference model: transaction phase 0 idle / 1 streaming / 2 responding.
  int          m_phase;
  logic        m_last;
  logic [31:0] m_word, m_cap;
  logic        m_to;
  int          m_wait;

  function automatic logic grantee();
    if (req0_vld_i && req1_vld_i) return !m_last;
    return req1_vld_i;
  endfunction

  function automatic logic will_grant();
    return (m_phase == 0) && !prst_i && (req0_vld_i || req1_vld_i);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_last = 1'b1; m_word = 32'd0; m_cap = 32'd0; m_to = 1'b0; m_wait = 0;
  endtask

  task automatic model_check();
    logic g;
    g = grantee();
    chk("m_rdy0", req0_rdy_o, will_grant() && !g);
    chk("m_rdy1", req1_rdy_o, will_grant() && g);
    chk("m_svld", stream_data_vld_o, m_phase == 1);
    chk("m_sdata", stream_data_o, m_word);
    chk("m_resp0", resp0_vld_o, (m_phase == 2) && !m_last);
    chk("m_resp1", resp1_vld_o, (m_phase == 2) && m_last);
    chk("m_busy", busy_o, m_phase != 0);
    chk("m_owner", owner_o, m_last);
    chk("m_timeout", timeout_o, (m_phase == 2) && m_to);
    if (m_phase == 2) chk("m_rdata", resp_data_o, m_cap);
  endtask

  task automatic model_step();
    logic g;
    if (prst_i) begin
      model_reset();
    end else if (m_phase == 0) begin
      if (req0_vld_i || req1_vld_i) begin
        g = grantee();
        m_last = g;
        m_word = g ? req1_data_i : req0_data_i;
        m_cap = 32'd0;
        m_wait = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_wait++;
      if (spi_data_rx_vld_i) m_cap = spi_data_rx_i;
      if (eot_i) begin
        m_phase = 2; m_to = 1'b0;
      end else if (TO_EN && (m_wait == int'(TO) - 1)) begin
        m_phase = 2; m_to = 1'b1; m_cap = 32'h0bad_da7a;
      end
    end else begin
      m_phase = 0; m_to = 1'b0;
    end
  endtask

  initial begin
    logic g;
    bit   got;

    vt[0]  = '{1'b1,1'b0,32'h1234_abcd,32'h0,1'b0,1'b0,32'h0,       1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'h0,32'h0};
    vt[1]  = '{1'b0,1'b1,32'h0,32'h9999_0000,1'b0,1'b1,32'h55,      1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,32'h1234_abcd,32'h0};
    vt[2]  = '{1'b0,1'b0,32'h0,32'h0,1'b1,1'b0,32'h0,               1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,32'h1234_abcd,32'h0};
    vt[3]  = '{1'b1,1'b0,32'hdead_0003,32'h0,1'b0,1'b0,32'h0,       1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,32'h1234_abcd,32'h55};
    vt[4]  = '{1'b0,1'b0,32'h0,32'h0,1'b1,1'b1,32'h77,              1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h1234_abcd,32'h0};
    vt[5]  = '{1'b0,1'b0,32'h0,32'h0,1'b0,1'b0,32'h0,               1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h1234_abcd,32'h0};
    vt[6]  = '{1'b0,1'b1,32'h0,32'hcafe_0001,1'b0,1'b0,32'h0,       1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h1234_abcd,32'h0};
    vt[7]  = '{1'b0,1'b0,32'h0,32'h0,1'b1,1'b1,32'ha5,              1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,32'hcafe_0001,32'h0};
    vt[8]  = '{1'b0,1'b0,32'h0,32'h0,1'b0,1'b0,32'h0,               1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,32'hcafe_0001,32'ha5};
    vt[9]  = '{1'b1,1'b0,32'h1111_2222,32'h0,1'b0,1'b0,32'h0,       1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'hcafe_0001,32'h0};
    vt[10] = '{1'b0,1'b0,32'h0,32'h0,1'b1,1'b0,32'h0,               1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,32'h1111_2222,32'h0};
    vt[11] = '{1'b0,1'b0,32'h0,32'h0,1'b0,1'b0,32'h0,               1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,32'h1111_2222,32'h0};
    vt[12] = '{1'b1,1'b1,32'h3333_0000,32'h4444_0000,1'b0,1'b0,32'h0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h1111_2222,32'h0};

    do_reset(1'b1);

    for (int i = 0; i < 13; i++) begin
      req0_vld_i = vt[i].r0; req1_vld_i = vt[i].r1;
      req0_data_i = vt[i].d0; req1_data_i = vt[i].d1;
      eot_i = vt[i].eot; spi_data_rx_vld_i = vt[i].rxv; spi_data_rx_i = vt[i].rx;
      @(negedge pclk_i);
      chk($sformatf("v%0d_rdy0", i), req0_rdy_o, vt[i].e_rdy0);
      chk($sformatf("v%0d_rdy1", i), req1_rdy_o, vt[i].e_rdy1);
      chk($sformatf("v%0d_svld", i), stream_data_vld_o, vt[i].e_svld);
      chk($sformatf("v%0d_sdata", i), stream_data_o, vt[i].e_sdata);
      chk($sformatf("v%0d_resp0", i), resp0_vld_o, vt[i].e_resp0);
      chk($sformatf("v%0d_resp1", i), resp1_vld_o, vt[i].e_resp1);
      chk($sformatf("v%0d_busy", i), busy_o, vt[i].e_busy);
      chk($sformatf("v%0d_owner", i), owner_o, vt[i].e_owner);
      chk($sformatf("v%0d_timeout", i), timeout_o, 1'b0);
      if (vt[i].e_resp0 || vt[i].e_resp1) chk($sformatf("v%0d_rdata", i), resp_data_o, vt[i].e_rdata);
      tick();
    end

    // Continuous contention must alternate starting with requester 0.
    do_reset(1'b0);
    req0_vld_i = 1'b1; req1_vld_i = 1'b1;
    req0_data_i = 32'h0000_0a0a; req1_data_i = 32'h0000_0b0b;
    for (int t = 0; t < 4; t++) begin
      got = 1'b0; g = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge pclk_i);
        if (req0_rdy_o || req1_rdy_o) begin
          got = 1'b1; g = req1_rdy_o;
        end
        tick();
      end
      chk($sformatf("alt%0d_granted", t), got, 1'b1);
      chk($sformatf("alt%0d_who", t), g, t[0]);
      eot_i = 1'b1;
      @(negedge pclk_i);
      chk($sformatf("alt%0d_owner", t), owner_o, t[0]);
      chk($sformatf("alt%0d_sdata", t), stream_data_o, t[0] ? 32'h0000_0b0b : 32'h0000_0a0a);
      tick();
      eot_i = 1'b0;
    end

    // Reset three cycles into the stream phase aborts silently and restores requester 0 priority.
    do_reset(1'b0);
    req0_vld_i = 1'b1; req0_data_i = 32'h0000_1111;
    @(negedge pclk_i);
    chk("abort_first_grant", req0_rdy_o, 1'b1);
    tick();
    req0_vld_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge pclk_i);
      chk($sformatf("abort_w%0d_svld", k), stream_data_vld_o, 1'b1);
      if (k == 2) prst_i = 1'b1;
      tick();
    end
    prst_i = 1'b0;
    req0_vld_i = 1'b1; req1_vld_i = 1'b1;
    @(negedge pclk_i);
    chk("abort_svld", stream_data_vld_o, 1'b0);
    chk("abort_resp0", resp0_vld_o, 1'b0);
    chk("abort_resp1", resp1_vld_o, 1'b0);
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_rdy0", req0_rdy_o, 1'b1);
    chk("abort_rdy1", req1_rdy_o, 1'b0);
    tick();
    clear_inputs();

    // Watchdog behaviour: expiry TO cycles after issue, or an indefinite wait when disabled.
    do_reset(1'b0);
    req0_vld_i = 1'b1; req0_data_i = 32'h0000_2222;
    @(negedge pclk_i);
    chk("wd_grant", req0_rdy_o, 1'b1);
    tick();
    req0_vld_i = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    for (int k = 1; k < int'(TO); k++) begin
      @(negedge pclk_i);
      chk($sformatf("wd_c%0d_svld", k), stream_data_vld_o, 1'b1);
      chk($sformatf("wd_c%0d_resp0", k), resp0_vld_o, 1'b0);
      tick();
    end
    @(negedge pclk_i);
    chk("wd_resp0", resp0_vld_o, 1'b1);
    chk("wd_timeout", timeout_o, 1'b1);
    chk("wd_rdata", resp_data_o, 32'h0bad_da7a);
    tick();
    @(negedge pclk_i);
    chk("wd_timeout_drop", timeout_o, 1'b0);
    chk("wd_idle", busy_o, 1'b0);
`else
    for (int k = 1; k <= 40; k++) begin
      @(negedge pclk_i);
      chk($sformatf("wd_c%0d_svld", k), stream_data_vld_o, 1'b1);
      chk($sformatf("wd_c%0d_resp0", k), resp0_vld_o, 1'b0);
      chk($sformatf("wd_c%0d_timeout", k), timeout_o, 1'b0);
      tick();
    end
    eot_i = 1'b1;
    tick();
    eot_i = 1'b0;
    @(negedge pclk_i);
    chk("wd_late_resp0", resp0_vld_o, 1'b1);
    chk("wd_late_rdata", resp_data_o, 32'd0);
`endif
    tick();

    // Randomized traffic against the reference model.
    do_reset(1'b0);
    model_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      prst_i = ($urandom_range(0, 99) == 0);
      req0_vld_i = $urandom_range(0, 1) == 1;
      req1_vld_i = $urandom_range(0, 1) == 1;
      req0_data_i = $urandom;
      req1_data_i = $urandom;
      spi_data_rx_vld_i = $urandom_range(0, 9) < 3;
      spi_data_rx_i = $urandom;
      eot_i = $urandom_range(0, 99) < 15;
      @(negedge pclk_i);
      model_check();
      model_step();
      tick();
    end
    clear_inputs();
    prst_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
